// File: rtl/cic_decim_n_if.sv
// Sample-stream interface for the CIC decimator.
// Master drives the input stream and runtime controls; slave (the decimator)
// returns the decimated samples with their update and saturation strobes.
//   clk_enable : input sample valid
//   clear      : synchronous flush of all filter state
//   factor     : decimation factor R (clamped inside the filter)
//   gain_shift : output arithmetic right shift (clamped inside the filter)
//   filter_in  : signed input sample
//   filter_out : signed decimated output, held between strobes
//   ce_out     : one-cycle pulse when filter_out updates
//   sat_out    : one-cycle pulse with ce_out when the sample clipped
interface cic_decim_n_if #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 16
);
  logic                           clk_enable;
  logic                           clear;
  logic        [15:0]             factor;
  logic        [5:0]              gain_shift;
  logic signed [INPUT_WIDTH-1:0]  filter_in;
  logic signed [OUTPUT_WIDTH-1:0] filter_out;
  logic                           ce_out;
  logic                           sat_out;

  modport master (
    output clk_enable, clear, factor, gain_shift, filter_in,
    input  filter_out, ce_out, sat_out
  );

  modport slave (
    input  clk_enable, clear, factor, gain_shift, filter_in,
    output filter_out, ce_out, sat_out
  );
endinterface

// File: rtl/cic_decim_n.sv
// N-stage CIC decimator: integrators at the input rate, combs at the output rate.
// Runtime decimation factor, rounded gain shift, output saturation and a
// synchronous flush.
//   clk     : clock
//   reset_n : asynchronous reset, active low
//   io_bus  : sample stream / control / output (see cic_decim_n_if)
module cic_decim_n #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 16,
  parameter int STAGES       = 3,
  parameter int DIFF_DELAY   = 1,
  parameter int MAX_FACTOR   = 256
) (
  input logic         clk,
  input logic         reset_n,
  cic_decim_n_if.slave io_bus
);
  localparam int ACC_WIDTH = INPUT_WIDTH + STAGES * $clog2(MAX_FACTOR * DIFF_DELAY);

  logic signed [INPUT_WIDTH-1:0]  r_in_q;
  logic        [ACC_WIDTH-1:0]    r_integ [STAGES];
  logic        [15:0]             r_cnt;
  // bit 0 loads the comb input, bit k fires comb k, top bit fires the output stage
  logic        [STAGES+1:0]       r_strb_sr;
  logic        [ACC_WIDTH-1:0]    r_c_in;
  logic        [ACC_WIDTH-1:0]    r_comb  [STAGES];
  logic        [ACC_WIDTH-1:0]    r_dly   [STAGES][DIFF_DELAY];
  logic signed [OUTPUT_WIDTH-1:0] r_out;
  logic                           r_ce;
  logic                           r_sat;

  logic                           w_strb;
  logic        [15:0]             w_factor;
  logic        [ACC_WIDTH-1:0]    w_in_ext;
  logic        [ACC_WIDTH-1:0]    w_comb_in [STAGES];
  logic        [5:0]              w_shift;
  logic signed [ACC_WIDTH:0]      w_rnd;
  logic signed [ACC_WIDTH:0]      w_v;
  logic signed [ACC_WIDTH:0]      w_r;
  logic                           w_clip;
  logic signed [OUTPUT_WIDTH-1:0] w_sat_val;

  always_comb begin
    if (io_bus.factor < 16'd2) begin
      w_factor = 16'd2;
    end else if (io_bus.factor > 16'(MAX_FACTOR)) begin
      w_factor = 16'(MAX_FACTOR);
    end else begin
      w_factor = io_bus.factor;
    end
  end

  assign w_strb   = io_bus.clk_enable && (r_cnt == '0);
  assign w_in_ext = {{(ACC_WIDTH - INPUT_WIDTH){r_in_q[INPUT_WIDTH-1]}}, r_in_q};

  // Input-rate section: stalls whenever clk_enable is low. Wraps modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_q <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < STAGES; k++) r_integ[k] <= '0;
    end else if (io_bus.clear) begin
      r_in_q <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < STAGES; k++) r_integ[k] <= '0;
    end else if (io_bus.clk_enable) begin
      r_in_q     <= io_bus.filter_in;
      r_integ[0] <= r_integ[0] + w_in_ext;
      for (int k = 1; k < STAGES; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
      // factor is only looked at here, so a new value starts a fresh period
      r_cnt <= w_strb ? (w_factor - 16'd1) : (r_cnt - 16'd1);
    end
  end

  always_comb begin
    w_comb_in[0] = r_c_in;
    for (int k = 1; k < STAGES; k++) w_comb_in[k] = r_comb[k-1];
  end

  // Output stage: round half up, arithmetic shift, then clip to OUTPUT_WIDTH.
  always_comb begin
    w_shift = io_bus.gain_shift;
    if (int'(io_bus.gain_shift) > ACC_WIDTH - 1) w_shift = 6'(ACC_WIDTH - 1);
    w_rnd = '0;
    if (w_shift != 6'd0) w_rnd = (ACC_WIDTH + 1)'(1) << (w_shift - 6'd1);
    // one guard bit so the rounding add cannot overflow
    w_v    = $signed({r_comb[STAGES-1][ACC_WIDTH-1], r_comb[STAGES-1]}) + w_rnd;
    w_r    = w_v >>> w_shift;
    w_clip = (w_r[ACC_WIDTH:OUTPUT_WIDTH-1] != '0) && (w_r[ACC_WIDTH:OUTPUT_WIDTH-1] != '1);
    if (!w_clip) begin
      w_sat_val = w_r[OUTPUT_WIDTH-1:0];
    end else if (w_r[ACC_WIDTH]) begin
      w_sat_val = {1'b1, {(OUTPUT_WIDTH - 1){1'b0}}};
    end else begin
      w_sat_val = {1'b0, {(OUTPUT_WIDTH - 1){1'b1}}};
    end
  end

  // Output-rate section: advances every cycle so an in-flight sample always completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strb_sr <= '0;
      r_c_in    <= '0;
      r_out     <= '0;
      r_ce      <= 1'b0;
      r_sat     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_comb[k] <= '0;
        for (int d = 0; d < DIFF_DELAY; d++) r_dly[k][d] <= '0;
      end
    end else if (io_bus.clear) begin
      r_strb_sr <= '0;
      r_c_in    <= '0;
      r_out     <= '0;
      r_ce      <= 1'b0;
      r_sat     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_comb[k] <= '0;
        for (int d = 0; d < DIFF_DELAY; d++) r_dly[k][d] <= '0;
      end
    end else begin
      r_strb_sr <= {r_strb_sr[STAGES:0], w_strb};
      if (r_strb_sr[0]) r_c_in <= r_integ[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        if (r_strb_sr[k+1]) begin
          r_comb[k]   <= w_comb_in[k] - r_dly[k][DIFF_DELAY-1];
          r_dly[k][0] <= w_comb_in[k];
          for (int d = 1; d < DIFF_DELAY; d++) r_dly[k][d] <= r_dly[k][d-1];
        end
      end
      r_ce <= r_strb_sr[STAGES+1];
      if (r_strb_sr[STAGES+1]) begin
        r_out <= w_sat_val;
        r_sat <= w_clip;
      end else begin
        r_sat <= 1'b0;
      end
    end
  end

  assign io_bus.filter_out = r_out;
  assign io_bus.ce_out     = r_ce;
  assign io_bus.sat_out    = r_sat;
endmodule

// File: tb/tb_cic_decim_n.sv
// Testbench for cic_decim_n. The reference model describes the filter as the
// N-fold running sum of the accepted samples (closed-form binomial weights),
// sampled at the strobe indices, differenced N times with lag M at the output
// rate, then rounded, shifted and clipped. Expected outputs (value, saturation
// flag and the cycle on which ce_out must appear) go into a queue; a monitor
// pops and compares on every ce_out.
module tb_cic_decim_n;
  localparam int IW   = 12;
  localparam int OW   = 16;
  localparam int N    = 3;
  localparam int M    = 1;
  localparam int MAXF = 256;
  localparam int ACC  = IW + N * $clog2(MAXF * M);

  typedef struct {
    int ecyc;
    int val;
    bit sat;
  } exp_t;

  logic   clk     = 1'b0;
  logic   reset_n = 1'b0;
  int     total   = 0;
  int     bad     = 0;
  int     cyc     = 0;
  int     out_sum = 0;
  int     xs[$];
  longint cins[$];
  int     next_strobe = 0;
  exp_t   expq[$];
  exp_t   mon_e;
  int     fopts[6] = '{1, 2, 3, 5, 7, 16};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_decim_n_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  cic_decim_n #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .STAGES      (N),
    .DIFF_DELAY  (M),
    .MAX_FACTOR  (MAXF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  task automatic check(input string name, input longint act, input longint exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic longint binom(input int a, input int b);
    longint r = 1;
    if (a < b || a < 0) return 0;
    for (int i = 0; i < b; i++) r = r * longint'(a - i) / longint'(i + 1);
    return r;
  endfunction

  function automatic longint wrap_acc(input longint v);
    longint t;
    t = v <<< (64 - ACC);
    return t >>> (64 - ACC);
  endfunction

  function automatic int clamp_factor(input int f);
    if (f < 2) return 2;
    if (f > MAXF) return MAXF;
    return f;
  endfunction

  function automatic void shape(input longint y, input int gs, output int val, output bit sat);
    int     sh;
    longint v, r, hi, lo;
    sh = (gs > ACC - 1) ? ACC - 1 : gs;
    v  = y;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    r   = v >>> sh;
    hi  = (longint'(1) <<< (OW - 1)) - 1;
    lo  = -(longint'(1) <<< (OW - 1));
    sat = 1'b0;
    val = int'(r);
    if (r > hi) begin
      val = int'(hi);
      sat = 1'b1;
    end else if (r < lo) begin
      val = int'(lo);
      sat = 1'b1;
    end
  endfunction

  // Sample x is accepted on clock edge edge_n.
  task automatic model_sample(input int x, input int edge_n);
    int     n, k;
    longint c, y;
    exp_t   e;
    n = xs.size();
    if (n == next_strobe) begin
      c = 0;
      for (int j = 0; j < n; j++) c += binom(n - 1 - j, N - 1) * longint'(xs[j]);
      cins.push_back(c);
      k = cins.size() - 1;
      y = 0;
      for (int i = 0; i <= N; i++) begin
        if (k - i * M >= 0) y += longint'((i % 2) ? -1 : 1) * binom(N, i) * cins[k - i * M];
      end
      y      = wrap_acc(y);
      e.ecyc = edge_n + N + 2;
      shape(y, int'(bus.gain_shift), e.val, e.sat);
      expq.push_back(e);
      next_strobe = n + clamp_factor(int'(bus.factor));
    end
    xs.push_back(x);
  endtask

  // Forget all state; outputs due on or after cycle lim will never appear.
  task automatic model_flush(input int lim);
    exp_t keep[$];
    foreach (expq[i]) if (expq[i].ecyc < lim) keep.push_back(expq[i]);
    expq = keep;
    xs.delete();
    cins.delete();
    next_strobe = 0;
  endtask

  // Called at posedge+1; inputs are sampled by the next edge (cyc+1).
  task automatic drive(input bit en, input int x, input bit clr);
    bus.clk_enable = en;
    bus.filter_in  = IW'(x);
    bus.clear      = clr;
    if (clr) model_flush(cyc + 1);
    else if (en) model_sample(x, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic dc(input int n, input int x);
    for (int i = 0; i < n; i++) drive(1'b1, x, 1'b0);
  endtask

  task automatic clear_check();
    drive(1'b1, 555, 1'b1);  // clear must win over clk_enable
    bus.clear      = 1'b0;
    bus.clk_enable = 1'b0;
    @(negedge clk);
    check("clear filter_out", bus.filter_out, 0);
    check("clear ce_out", bus.ce_out, 0);
    check("clear sat_out", bus.sat_out, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.clk_enable = 1'b0;
    bus.clear      = 1'b0;
    reset_n        = 1'b0;
    model_flush(cyc);
    @(negedge clk);
    check("reset filter_out", bus.filter_out, 0);
    check("reset ce_out", bus.ce_out, 0);
    check("reset sat_out", bus.sat_out, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.ce_out) begin
          if (expq.size() == 0) begin
            check("spurious ce_out", bus.ce_out, 0);
          end else begin
            mon_e = expq.pop_front();
            check("ce_out cycle", cyc, mon_e.ecyc);
            check("filter_out", bus.filter_out, mon_e.val);
            check("sat_out", bus.sat_out, mon_e.sat);
            out_sum = out_sum + int'(bus.filter_out);
          end
        end else begin
          if (bus.sat_out) check("sat_out without ce_out", bus.sat_out, 0);
          if (expq.size() > 0 && expq[0].ecyc <= cyc) begin
            mon_e = expq.pop_front();
            check("missing ce_out", bus.ce_out, 1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus.clk_enable = 1'b0;
    bus.clear      = 1'b0;
    bus.factor     = 16'd4;
    bus.gain_shift = 6'd6;
    bus.filter_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("por filter_out", bus.filter_out, 0);
    check("por ce_out", bus.ce_out, 0);
    check("por sat_out", bus.sat_out, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // DC 100, R=4, unity-gain shift
    dc(40, 100);
    idle(N + 4);
    check("dc100 settled", bus.filter_out, 100);

    // Saturation both ways
    clear_check();
    bus.gain_shift = 6'd0;
    dc(30, 2047);
    idle(N + 4);
    check("sat positive", bus.filter_out, 32767);
    clear_check();
    dc(30, -2048);
    idle(N + 4);
    check("sat negative", bus.filter_out, -32768);

    // Impulse on every input phase: taps add up to R^N
    for (int p = 0; p < 4; p++) begin
      clear_check();
      if (p == 0) out_sum = 0;
      for (int i = 0; i < 16; i++) drive(1'b1, (i == p) ? 1 : 0, 1'b0);
      idle(N + 4);
    end
    check("impulse tap sum", out_sum, 64);

    // Factor 8 -> 2 mid-stream, changed just after the strobe-40 output left
    clear_check();
    bus.factor     = 16'd8;
    bus.gain_shift = 6'd9;
    for (int i = 0; i < 110; i++) begin
      if (i == 46) begin
        bus.factor     = 16'd2;
        bus.gain_shift = 6'd3;
      end
      drive(1'b1, 100, 1'b0);
    end
    idle(N + 4);
    check("factor change settled", bus.filter_out, 100);

    // Accumulator wrap at R=256 (factor clamped from 1000)
    clear_check();
    bus.factor     = 16'd1000;
    bus.gain_shift = 6'd24;
    dc(3000, 2047);
    idle(N + 4);
    check("wrap dc", bus.filter_out, 2047);

    // Random data, gaps, factors and shifts; clear and reset mid-period
    for (int seg = 0; seg < 6; seg++) begin
      clear_check();
      bus.factor     = 16'(fopts[$urandom_range(0, 5)]);
      bus.gain_shift = 6'($urandom_range(0, 8));
      for (int i = 0; i < 120; i++) begin
        if (seg == 2 && i == 53) do_reset();
        else if (seg == 4 && i == 37) clear_check();
        else drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)) - 2048, 1'b0);
      end
    end

    idle(N + 6);
    check("scoreboard drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
